// File: rtl/priority_bit_scanner.sv
// ---------------------------------------------------------------------------
// priority_bit_scanner
//
// Purpose:
//   Streams every set bit of an accepted WIDTH-bit word, one beat per cycle,
//   in priority order (lowest set bit first, or highest set bit first when
//   MSB_FIRST=1). Each beat carries the one-hot mask and the binary index of
//   the bit. An all-zero word produces exactly one beat flagged bit_zero_o.
//
// Handshakes (both sides):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   valid never drops before its transfer, and the payload stays stable while
//   valid=1 and ready=0. ready may depend combinationally on the far side's
//   ready only for data_rdy_o, which follows bit_rdy_i on a last beat so that
//   consecutive words stream without a bubble.
//
// Ports:
//   clk_i         in   1      clock
//   rst_n_i       in   1      asynchronous active-low reset
//   data_i        in   WIDTH  input word (sampled only on accept)
//   data_val_i    in   1      input word valid
//   data_rdy_o    out  1      block can accept a word this cycle
//   bit_onehot_o  out  WIDTH  one-hot mask of the current bit ('0 on a zero-word beat)
//   bit_idx_o     out  IDX_W  index of the current bit (0 on a zero-word beat)
//   bit_last_o    out  1      current beat is the final beat of the word
//   bit_zero_o    out  1      current beat reports an all-zero input word
//   bit_val_o     out  1      beat valid
//   bit_rdy_i     in   1      consumer accepts the beat
//   dbg_state_o   out  1      FSM state for observation (0: IDLE, 1: EMIT)
// ---------------------------------------------------------------------------
module priority_bit_scanner #(
   parameter int WIDTH     = 16,
   parameter int IDX_W     = $clog2(WIDTH),
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             data_val_i,
   output logic             data_rdy_o,
   output logic [WIDTH-1:0] bit_onehot_o,
   output logic [IDX_W-1:0] bit_idx_o,
   output logic             bit_last_o,
   output logic             bit_zero_o,
   output logic             bit_val_o,
   input  logic             bit_rdy_i,
   output logic             dbg_state_o
);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_e;

   state_e           state_q;
   state_e           state_n;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] rem_n;

   logic             beat_hs;
   logic             accept;
   logic             load_beat;
   logic             end_word;

   logic [WIDTH-1:0] onehot_n;
   logic [IDX_W-1:0] idx_n;
   logic             last_n;
   logic             zero_n;

   // Isolate the bit that has priority in v. For LSB-first this is the
   // classic two's-complement trick, naturally truncated to WIDTH bits.
   // For MSB-first the ascending scan keeps overwriting, so the highest
   // set bit wins.
   function automatic logic [WIDTH-1:0] isolate(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
               r = WIDTH'(1) << i;
            end
         end
      end else begin
         r = v & (~v + WIDTH'(1));
      end
      return r;
   endfunction

   // Binary encoding of a one-hot (or all-zero) mask.
   function automatic logic [IDX_W-1:0] encode(input logic [WIDTH-1:0] oh);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (oh[i]) begin
            r = r | IDX_W'(i);
         end
      end
      return r;
   endfunction

   always_comb begin
      beat_hs    = bit_val_o & bit_rdy_i;
      end_word   = beat_hs & bit_last_o;
      data_rdy_o = (state_q == IDLE) | end_word;
      accept     = data_val_i & data_rdy_o;
      load_beat  = accept | (beat_hs & ~bit_last_o);

      rem_n   = rem_q;
      state_n = state_q;
      if (accept) begin
         // A new word also wins over the final beat of the previous one,
         // keeping the FSM in EMIT with no bubble.
         rem_n   = data_i;
         state_n = EMIT;
      end else if (beat_hs) begin
         if (bit_last_o) begin
            state_n = IDLE;
         end else begin
            rem_n = rem_q & ~bit_onehot_o;
         end
      end

      // Beat fields are computed from the remaining-bits value that will be
      // current after this edge, then registered.
      onehot_n = isolate(rem_n);
      idx_n    = encode(onehot_n);
      last_n   = ((rem_n & (rem_n - WIDTH'(1))) == '0);
      zero_n   = (rem_n == '0);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         rem_q        <= '0;
         bit_val_o    <= 1'b0;
         bit_onehot_o <= '0;
         bit_idx_o    <= '0;
         bit_last_o   <= 1'b0;
         bit_zero_o   <= 1'b0;
      end else begin
         state_q <= state_n;
         rem_q   <= rem_n;
         if (load_beat) begin
            bit_val_o    <= 1'b1;
            bit_onehot_o <= onehot_n;
            bit_idx_o    <= idx_n;
            bit_last_o   <= last_n;
            bit_zero_o   <= zero_n;
         end else if (end_word) begin
            // Word finished with nothing queued behind it: go quiet.
            bit_val_o    <= 1'b0;
            bit_onehot_o <= '0;
            bit_idx_o    <= '0;
            bit_last_o   <= 1'b0;
            bit_zero_o   <= 1'b0;
         end
      end
   end

   assign dbg_state_o = (state_q == EMIT);

endmodule
